// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Offset from the start-bit edge to the middle of the start bit.
   function automatic int half_bit(input int clks_per_bit);
      return (clks_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value selectable so
// idle-high lines come out of reset in their idle state.
module sync_2ff #(
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= {WIDTH{RESET_VAL}};
         q    <= {WIDTH{RESET_VAL}};
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, start-edge detect, mid-bit sampling,
// one-cycle rx_valid / frame_err pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
   localparam int CW       = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   logic              rx_s;
   logic              rx_d;
   logic              fall_edge;
   uart_state_t       state;
   logic [CW-1:0]     clk_count;
   logic [2:0]        bit_idx;
   logic [7:0]        shift_reg;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_serial_in),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_d <= 1'b1;
      end else begin
         rx_d <= rx_s;
      end
   end

   // Only a genuine high-to-low transition arms reception; a stuck-low line does not.
   assign fall_edge = rx_d & ~rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         clk_count <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            IDLE: begin
               clk_count <= '0;
               bit_idx   <= '0;
               if (fall_edge) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (clk_count == HALF_CNT) begin
                  clk_count <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     // Line went back high before mid start bit: treat as noise.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end

            DATA: begin
               if (clk_count == LAST_CNT) begin
                  clk_count <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == LAST_BIT) begin
                     state <= STOP;
                  end
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end

            STOP: begin
               if (clk_count == LAST_CNT) begin
                  clk_count <= '0;
                  state     <= IDLE;
                  busy      <= 1'b0;
                  if (rx_s) begin
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  clk_count <= clk_count + 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               clk_count <= '0;
               bit_idx   <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx: serial frames are driven bit by bit
// and every output pulse is matched against a queue of expected frame outcomes.
module tb_uart_rx;

   localparam int CPB      = 8;
   localparam int HALF     = (CPB - 1) / 2;
   localparam int LAT_MIN  = (19 * CPB) / 2 + 3;
   localparam int LAT_MAX  = (19 * CPB) / 2 + 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_serial_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_serial_in (rx_serial_in),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         t0;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] model_data = 8'h00;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         n_valid = 0;
   int         n_err = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Compare process: every pulse must match the oldest expected frame outcome.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         check("reset_outputs", int'({rx_valid, frame_err, busy, rx_data}), 0);
      end else begin
         if (rx_valid || frame_err) begin
            check("pulse_exclusive", int'(rx_valid & frame_err), 0);
            if (rx_valid) n_valid++;
            if (frame_err) n_err++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse actual valid=%0b err=%0b required none t=%0t",
                        rx_valid, frame_err, $time);
            end else begin
               ev_t ev;
               int  lat;
               ev  = exp_q.pop_front();
               lat = cyc - ev.t0;
               check("pulse_kind_err", int'(frame_err), int'(ev.is_err));
               checks++;
               if (lat < LAT_MIN || lat > LAT_MAX) begin
                  failures++;
                  $display("FAIL pulse_latency actual=%0d required=%0d..%0d", lat, LAT_MIN, LAT_MAX);
               end
               if (!ev.is_err) model_data = ev.data;
            end
         end
         check("rx_data_hold", int'(rx_data), int'(model_data));
         if (exp_q.size() > 0 && (cyc - exp_q[0].t0) > LAT_MAX) begin
            checks++;
            failures++;
            $display("FAIL missing_pulse actual=none required err=%0b data=0x%0h",
                     exp_q[0].is_err, exp_q[0].data);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic drive_bit(input logic v);
      rx_serial_in = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_serial_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller is aligned at posedge+1; frame occupies exactly 10*CPB cycles.
   task automatic send(input logic [7:0] b, input bit stop_ok);
      ev_t ev;
      ev.is_err = !stop_ok;
      ev.data   = b;
      ev.t0     = cyc;
      exp_q.push_back(ev);
      drive_bit(1'b0);
      drive_bit(b[0]);
      check("busy_mid_frame", int'(busy), 1);
      for (int i = 1; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok ? 1'b1 : 1'b0);
      rx_serial_in = 1'b1;
   endtask

   int v0, e0;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", int'({rx_valid, frame_err, busy, rx_data}), 0);
      rst_n = 1'b1;
      idle(4 * CPB);

      // 1: single good frame
      v0 = n_valid; e0 = n_err;
      send(8'hA5, 1'b1);
      idle(2 * CPB);
      check("t1_valid_count", n_valid - v0, 1);
      check("t1_err_count", n_err - e0, 0);
      check("t1_rx_data", int'(rx_data), 'hA5);
      check("t1_busy_after", int'(busy), 0);

      // 2: back-to-back frames
      v0 = n_valid; e0 = n_err;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h3C, 1'b1);
      idle(2 * CPB);
      check("t2_valid_count", n_valid - v0, 3);
      check("t2_err_count", n_err - e0, 0);
      check("t2_rx_data", int'(rx_data), 'h3C);

      // 3: short glitch
      v0 = n_valid; e0 = n_err;
      rx_serial_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      idle(HALF + 4);
      check("t3_busy_cleared", int'(busy), 0);
      idle(12 * CPB);
      check("t3_valid_count", n_valid - v0, 0);
      check("t3_err_count", n_err - e0, 0);

      // 4: bad stop bit, then recovery
      v0 = n_valid; e0 = n_err;
      send(8'h55, 1'b0);
      idle(2 * CPB);
      check("t4_err_count", n_err - e0, 1);
      check("t4_rx_data_kept", int'(rx_data), 'h3C);
      send(8'h12, 1'b1);
      idle(2 * CPB);
      check("t4_valid_count", n_valid - v0, 1);
      check("t4_rx_data", int'(rx_data), 'h12);

      // 5: break condition
      v0 = n_valid; e0 = n_err;
      begin
         ev_t ev;
         ev.is_err = 1'b1;
         ev.data   = 8'h00;
         ev.t0     = cyc;
         exp_q.push_back(ev);
      end
      rx_serial_in = 1'b0;
      repeat (30 * CPB) @(posedge clk);
      #1;
      idle(2 * CPB);
      send(8'h81, 1'b1);
      idle(2 * CPB);
      check("t5_err_count", n_err - e0, 1);
      check("t5_valid_count", n_valid - v0, 1);
      check("t5_rx_data", int'(rx_data), 'h81);

      // 6: reset during data bit 4 of 0xC3
      v0 = n_valid; e0 = n_err;
      begin
         logic [7:0] b;
         b = 8'hC3;
         drive_bit(1'b0);
         for (int i = 0; i < 4; i++) drive_bit(b[i]);
         rx_serial_in = b[4];
         repeat (CPB / 2) @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("t6_async_reset", int'({rx_valid, frame_err, busy, rx_data}), 0);
      exp_q.delete();
      model_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2 * CPB);
      check("t6_no_pulse_aborted", n_valid + n_err - v0 - e0, 0);
      send(8'h7E, 1'b1);
      idle(2 * CPB);
      check("t6_valid_count", n_valid - v0, 1);
      check("t6_rx_data", int'(rx_data), 'h7E);

      // Randomised traffic: random bytes, occasional bad stop, random gaps.
      for (int k = 0; k < 24; k++) begin
         send(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0);
         idle($urandom_range(0, 3) * CPB + $urandom_range(0, 5));
      end
      idle(12 * CPB);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
